// File: rtl/salu_pkg.sv
// salu_pkg: opcodes, branch decode and response entry for the scalar ALU sequencer; SALU_SEQ_OVF_TRAP_EN adds the ovf field
package salu_pkg;
  localparam int SALU_DW = 32;
  typedef enum logic [3:0] {
    OP_ADD  = 4'b0000, OP_SUB  = 4'b0001, OP_AND  = 4'b0010, OP_OR   = 4'b0011,
    OP_XOR  = 4'b0100, OP_SLL  = 4'b0101, OP_SRL  = 4'b0110, OP_SRA  = 4'b0111,
    OP_SLT  = 4'b1000, OP_SLTU = 4'b1001, OP_BEQ  = 4'b1010, OP_BNE  = 4'b1011,
    OP_BLT  = 4'b1100, OP_BGE  = 4'b1101, OP_BLTU = 4'b1110, OP_BGEU = 4'b1111
  } alu_op_e;
  function automatic logic is_branch(input logic [3:0] op);
    return op[3] & (op[2] | op[1]);
  endfunction
  typedef struct packed {
    logic [4:0]         rd;
    logic [SALU_DW-1:0] data;
    logic               wb_en;
    logic               branch;
    logic               taken;
    logic [SALU_DW-1:0] target;
`ifdef SALU_SEQ_OVF_TRAP_EN
    logic               ovf;
`endif
  } rsp_t;
endpackage

// File: rtl/salu_rsp_fifo.sv
// salu_rsp_fifo: circular response FIFO with struct payload, head output forced to zero when empty
module salu_rsp_fifo
  import salu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter type T = rsp_t
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  T                           din_i,
  input  logic                       pop_i,
  output T                           dout_o,
  output logic                       valid_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  T mem_q [DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic pop;
  assign valid_o = cnt_q != '0;
  assign pop = pop_i & valid_o;
  assign count_o = cnt_q;
  assign dout_o = valid_o ? mem_q[rd_q] : '0;
  // Pointers wrap at DEPTH so non-power-of-two depths also work
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wr_q <= (wr_q == PW'(DEPTH - 1)) ? '0 : wr_q + 1'b1;
      if (pop) rd_q <= (rd_q == PW'(DEPTH - 1)) ? '0 : rd_q + 1'b1;
      cnt_q <= cnt_q + CW'(push_i) - CW'(pop);
    end
  // Storage needs no reset: the head is masked while empty
  always_ff @(posedge clk)
    if (push_i) mem_q[wr_q] <= din_i;
endmodule

// File: rtl/salu_seq.sv
// salu_seq: issue/collect sequencer for the scalar ALU; SALU_SEQ_OVF_TRAP_EN enables overflow trap reporting
module salu_seq
  import salu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [3:0]            req_op_i,
  input  logic [DATA_WIDTH-1:0] req_rs1_i,
  input  logic [DATA_WIDTH-1:0] req_rs2_i,
  input  logic [4:0]            req_rd_i,
  input  logic [DATA_WIDTH-1:0] req_pc_i,
  input  logic [DATA_WIDTH-1:0] req_imm_i,
  output logic [DATA_WIDTH-1:0] alu_rs1_o,
  output logic [DATA_WIDTH-1:0] alu_rs2_o,
  output logic [3:0]            alu_op_o,
  input  logic [DATA_WIDTH-1:0] alu_res_i,
  input  logic                  alu_zero_i,
  input  logic                  alu_neg_i,
  input  logic                  alu_ovf_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [4:0]            rsp_rd_o,
  output logic [DATA_WIDTH-1:0] rsp_data_o,
  output logic                  rsp_wb_en_o,
  output logic                  rsp_branch_o,
  output logic                  rsp_taken_o,
  output logic [DATA_WIDTH-1:0] rsp_target_o,
  output logic                  rsp_ovf_o,
  output logic                  ovf_sticky_o,
  input  logic                  ovf_clr_i
);
  typedef struct packed {
    logic [4:0]            rd;
    logic [DATA_WIDTH-1:0] data;
    logic                  wb_en;
    logic                  branch;
    logic                  taken;
    logic [DATA_WIDTH-1:0] target;
`ifdef SALU_SEQ_OVF_TRAP_EN
    logic                  ovf;
`endif
  } entry_t;
  localparam int CW = $clog2(DEPTH + 1);
  logic accept, inflight_q, br;
  logic [4:0] rd_q;
  logic [3:0] op_q;
  logic [DATA_WIDTH-1:0] pc_q, imm_q;
  logic [CW-1:0] occ;
  entry_t push_d, head;
  assign req_ready_o = !rst && (int'(occ) + int'(inflight_q) < DEPTH);
  assign accept = req_valid_i & req_ready_o;
  assign alu_op_o = accept ? req_op_i : OP_ADD;
  assign alu_rs1_o = accept ? req_rs1_i : '0;
  assign alu_rs2_o = accept ? req_rs2_i : '0;
  assign br = is_branch(op_q);
  // Tag stage shadows the ALU's one-cycle latency
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      inflight_q <= 1'b0;
      rd_q <= '0;
      op_q <= '0;
      pc_q <= '0;
      imm_q <= '0;
    end else begin
      inflight_q <= accept;
      if (accept) begin
        rd_q <= req_rd_i;
        op_q <= req_op_i;
        pc_q <= req_pc_i;
        imm_q <= req_imm_i;
      end
    end
  // Build the response from the tag and the registered ALU outputs
  always_comb begin
    push_d = '0;
    push_d.rd = rd_q;
    push_d.data = alu_res_i;
    push_d.wb_en = !br && rd_q != '0;
    push_d.branch = br;
    push_d.taken = br & alu_zero_i;
    push_d.target = br ? pc_q + imm_q : '0;
`ifdef SALU_SEQ_OVF_TRAP_EN
    push_d.ovf = alu_ovf_i & (op_q == OP_ADD || op_q == OP_SUB);
`endif
  end
  salu_rsp_fifo #(.DEPTH(DEPTH), .T(entry_t)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push_i(inflight_q),
    .din_i(push_d),
    .pop_i(rsp_ready_i),
    .dout_o(head),
    .valid_o(rsp_valid_o),
    .count_o(occ)
  );
  assign rsp_rd_o = head.rd;
  assign rsp_data_o = head.data;
  assign rsp_wb_en_o = head.wb_en;
  assign rsp_branch_o = head.branch;
  assign rsp_taken_o = head.taken;
  assign rsp_target_o = head.target;
`ifdef SALU_SEQ_OVF_TRAP_EN
  logic sticky_q;
  logic unused_sig;
  assign unused_sig = alu_neg_i;
  assign rsp_ovf_o = head.ovf;
  assign ovf_sticky_o = sticky_q;
  // Sticky overflow: a new trap-worthy push beats a simultaneous clear
  always_ff @(posedge clk or posedge rst)
    if (rst) sticky_q <= 1'b0;
    else if (inflight_q && push_d.ovf) sticky_q <= 1'b1;
    else if (ovf_clr_i) sticky_q <= 1'b0;
`else
  logic unused_sig;
  assign unused_sig = ^{alu_neg_i, alu_ovf_i, ovf_clr_i};
  assign rsp_ovf_o = 1'b0;
  assign ovf_sticky_o = 1'b0;
`endif
endmodule
